gc_controller_poll: RTL and testbench
=====================================

Name: gc_controller_poll

Overview:
- Joybus master for one GameCube controller on a single open-drain data wire.
- Periodically sends the poll command 0x400302, receives the 64-bit status response and decodes it into registered button, stick and trigger outputs.
- These outputs feed the input viewer pixel pipeline (A/B/X/Y … R_TRIGGER).
- Outputs update atomically only after a complete, well-formed response.

Parameters:
- CLK_HZ, 100_000_000, system clock frequency; sets US_CYC = CLK_HZ/1_000_000 cycles per microsecond.
- POLL_HZ, 60, poll rate; sets POLL_CYC = CLK_HZ/POLL_HZ.
- RX_TIMEOUT_US, 200, maximum wait for the first response falling edge, and for each later bit edge.

Ports:
- clk  in  1  system clock, 100 MHz.
- reset  in  1  synchronous, active-low reset.
- data_in  in  1  raw level of the Joybus wire (asynchronous).
- data_oe  out  1  1 = pull the wire low; 0 = release (external pull-up).
- A, B, X, Y, start_pause, L, R, Z, D_UP, D_DOWN, D_RIGHT, D_LEFT  out  1 each  decoded digital buttons.
- JOY_X, JOY_Y, C_STICK_X, C_STICK_Y, L_TRIGGER, R_TRIGGER  out  8 each  analog values.
- connected  out  1  1 after a valid response; 0 after a timeout or framing error.
- update  out  1  one-cycle pulse when outputs are refreshed.

Behaviour:
- Reset (reset=0 on a rising clk edge):
  - data_oe=0; all buttons=0; JOY_X, JOY_Y, C_STICK_X, C_STICK_Y = 8'd128; triggers=0; connected=0; update=0.
  - Poll timer cleared; FSM goes to IDLE.
  - Reset mid-transfer aborts immediately and releases the line the same cycle.
- data_in passes through a 2-flop synchronizer before any use. Falling edge = synced prev 1, now 0.
- IDLE: count POLL_CYC cycles, then go to TX. The poll timer free-runs, so the period is independent of transfer length.
- TX: shift out 25 bits MSB-first: 0x400302, then a stop bit '1'. Each bit is 4*US_CYC cycles.
  - Bit '0': data_oe=1 for 3 µs, then 0 for 1 µs.
  - Bit '1': data_oe=1 for 1 µs, then 0 for 3 µs.
  - The stop bit is coded as '1'. Then go to RX_WAIT.
- RX_WAIT: wait for a falling edge.
  - On edge: start the bit timer and go to RX_SAMPLE.
  - If RX_TIMEOUT_US elapses first: go to ERROR.
- RX_SAMPLE: sample synced data at 2 µs after the falling edge and shift it into a 64-bit register, MSB first.
  - After 64 bits, go to RX_STOP.
  - Otherwise return to RX_WAIT, with the timeout counter reset at each bit.
- RX_STOP: require one more falling edge within the timeout (controller stop bit), then go to DONE. Timeout here goes to ERROR.
- DONE: validate response bits [63:61]==3'b000 and bit [55]==1.
  - If valid: latch all outputs in one cycle, assert connected=1, pulse update=1.
  - If invalid: go to ERROR.
  - Then return to IDLE.
- ERROR: connected=0; outputs hold their last valid values; update stays 0; return to IDLE.
- Response mapping, bit 63 = first received:
  - [60] start_pause, [59] Y, [58] X, [57] B, [56] A.
  - [54] L, [53] R, [52] Z, [51] D_UP, [50] D_DOWN, [49] D_RIGHT, [48] D_LEFT.
  - [47:40] JOY_X, [39:32] JOY_Y, [31:24] C_STICK_X, [23:16] C_STICK_Y, [15:8] L_TRIGGER, [7:0] R_TRIGGER.
- data_oe is never asserted outside TX.
- A poll tick that arrives while not in IDLE is held pending and serviced on return to IDLE; at most one tick is pending.

Optional Feature:
- Macro: GC_RUMBLE_EN.
- When defined:
  - Adds input port rumble (1 bit).
  - The last command byte is 0x03 when rumble=1, else 0x02.
  - rumble is sampled on entry to TX and held for the whole command.
- When undefined: no port; the command is always 0x400302.

Test Plan:
- Reset, check outputs, then run 1 ms of idle:
  - At reset: data_oe=0, JOY_X=128, connected=0.
  - First TX starts exactly POLL_CYC cycles after reset release.
- TX waveform: measure data_oe low/high times.
  - Bits decode as 0x400302 + stop bit.
  - '0' = 300 cycles low / 100 high; '1' = 100 low / 300 high; total 25*400 cycles.
- Controller model replies 0x0180_8080_8080_0000 after TX:
  - One update pulse.
  - Outputs: A=1, JOY_X=8'h80, D_LEFT=0, connected=1.
- Model replies with bits Start/Y/X/B/A=1, byte1=0xFF, bytes 2–7 = 0x10,0x20,0x30,0x40,0x50,0x60:
  - All buttons = 1.
  - JOY_X=0x10 … R_TRIGGER=0x60.
- No reply, then a reply truncated at bit 40:
  - ERROR both times; connected=0; prior values held; no update pulse.
  - Next good poll recovers.
- Reset asserted during TX bit 10 and again during RX bit 30:
  - data_oe=0 on the next cycle.
  - Next poll starts POLL_CYC cycles after reset release.
- With GC_RUMBLE_EN and rumble=1: last TX byte is 0x03. Toggling rumble mid-TX does not change the command.

Source files
------------

// File: rtl/gc_controller_poll.sv
// Joybus poll master for one GameCube controller: sends 0x400302, decodes the 64-bit reply.
// Define GC_RUMBLE_EN to add the rumble input, which selects 0x03 as the last command byte.
`timescale 1ns/1ps
module gc_controller_poll #(
    parameter int CLK_HZ        = 100_000_000,
    parameter int POLL_HZ       = 60,
    parameter int RX_TIMEOUT_US = 200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       data_in,
`ifdef GC_RUMBLE_EN
    input  logic       rumble,
`endif
    output logic       data_oe,
    output logic       A,
    output logic       B,
    output logic       X,
    output logic       Y,
    output logic       start_pause,
    output logic       L,
    output logic       R,
    output logic       Z,
    output logic       D_UP,
    output logic       D_DOWN,
    output logic       D_RIGHT,
    output logic       D_LEFT,
    output logic [7:0] JOY_X,
    output logic [7:0] JOY_Y,
    output logic [7:0] C_STICK_X,
    output logic [7:0] C_STICK_Y,
    output logic [7:0] L_TRIGGER,
    output logic [7:0] R_TRIGGER,
    output logic       connected,
    output logic       update
);

    localparam int US_CYC   = CLK_HZ / 1_000_000;
    localparam int POLL_CYC = CLK_HZ / POLL_HZ;
    localparam int BIT_CYC  = 4 * US_CYC;
    localparam int TO_CYC   = RX_TIMEOUT_US * US_CYC;
    localparam int CW       = $clog2((TO_CYC > BIT_CYC) ? TO_CYC : BIT_CYC) + 1;
    localparam int PW       = $clog2(POLL_CYC) + 1;

    typedef enum logic [2:0] {
        IDLE, TX, RX_WAIT, RX_SAMPLE, RX_STOP, DONE, ERROR
    } state_t;

    state_t          state_q, state_nxt;
    logic [2:0]      sync_q;
    logic [PW-1:0]   poll_q;
    logic            pending_q;
    logic [CW-1:0]   cyc_q;
    logic [6:0]      bit_q;
    logic [24:0]     tx_sr;
    logic [63:0]     rx_sr;
    logic [23:0]     cmd;

    logic tick, fall, bit_end, timeout, sample_pt, valid;

`ifdef GC_RUMBLE_EN
    assign cmd = {16'h4003, 7'b0000001, rumble};
`else
    assign cmd = 24'h400302;
`endif

    assign tick      = (poll_q == PW'(POLL_CYC - 1));
    assign fall      = sync_q[2] & ~sync_q[1];
    assign bit_end   = (cyc_q == CW'(BIT_CYC - 1));
    assign timeout   = (cyc_q == CW'(TO_CYC - 1));
    assign sample_pt = (cyc_q == CW'(2 * US_CYC - 1));
    assign valid     = (rx_sr[63:61] == 3'b000) && rx_sr[55];

    always_ff @(posedge clk) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_nxt;
    end

    always_comb begin
        // NOTE: defaulting every comb output up front keeps this block free of inferred latches.
        state_nxt = state_q;
        case (state_q)
            IDLE:      if (tick || pending_q) state_nxt = TX;
            TX:        if (bit_end && bit_q == 7'd24) state_nxt = RX_WAIT;
            RX_WAIT:   if (fall) state_nxt = RX_SAMPLE;
                       else if (timeout) state_nxt = ERROR;
            RX_SAMPLE: if (sample_pt) state_nxt = (bit_q == 7'd63) ? RX_STOP : RX_WAIT;
            RX_STOP:   if (fall) state_nxt = DONE;
                       else if (timeout) state_nxt = ERROR;
            DONE:      state_nxt = valid ? IDLE : ERROR;
            ERROR:     state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Releasing on the reset level itself frees the wire without waiting for an edge.
    always_comb begin
        data_oe = 1'b0;
        if (reset && state_q == TX)
            data_oe = tx_sr[24] ? (cyc_q < CW'(US_CYC)) : (cyc_q < CW'(3 * US_CYC));
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
        if (!reset) begin
            sync_q      <= 3'b111;
            poll_q      <= '0;
            pending_q   <= 1'b0;
            cyc_q       <= '0;
            bit_q       <= '0;
            {A, B, X, Y, start_pause}                   <= '0;
            {L, R, Z, D_UP, D_DOWN, D_RIGHT, D_LEFT}    <= '0;
            {JOY_X, JOY_Y, C_STICK_X, C_STICK_Y}        <= {4{8'd128}};
            {L_TRIGGER, R_TRIGGER}                      <= '0;
            connected   <= 1'b0;
            update      <= 1'b0;
        end else begin
            sync_q <= {sync_q[1:0], data_in};
            update <= 1'b0;
            poll_q <= tick ? '0 : poll_q + PW'(1);

            if (state_q == IDLE) pending_q <= 1'b0;
            else if (tick)       pending_q <= 1'b1;

            if (state_nxt != state_q || state_q == IDLE || (state_q == TX && bit_end))
                cyc_q <= '0;
            else
                cyc_q <= cyc_q + CW'(1);

            case (state_q)
                IDLE:      if (state_nxt == TX) bit_q <= '0;
                TX:        if (bit_end) bit_q <= (state_nxt == RX_WAIT) ? 7'd0 : bit_q + 7'd1;
                RX_SAMPLE: if (sample_pt) bit_q <= bit_q + 7'd1;
                DONE: begin
                    if (valid) begin
                        {start_pause, Y, X, B, A}                <= rx_sr[60:56];
                        {L, R, Z, D_UP, D_DOWN, D_RIGHT, D_LEFT} <= rx_sr[54:48];
                        JOY_X     <= rx_sr[47:40];
                        JOY_Y     <= rx_sr[39:32];
                        C_STICK_X <= rx_sr[31:24];
                        C_STICK_Y <= rx_sr[23:16];
                        L_TRIGGER <= rx_sr[15:8];
                        R_TRIGGER <= rx_sr[7:0];
                        connected <= 1'b1;
                        update    <= 1'b1;
                    end
                end
                ERROR:     connected <= 1'b0;
                default:   ;
            endcase
        end
    end

    // NOTE: shift registers are always fully loaded before they are read, so they carry no reset.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && state_nxt == TX)
            tx_sr <= {cmd, 1'b1};
        else if (state_q == TX && bit_end)
            tx_sr <= {tx_sr[23:0], 1'b0};

        if (state_q == RX_SAMPLE && sample_pt)
            rx_sr <= {rx_sr[62:0], sync_q[1]};
    end

endmodule

// File: tb/tb_gc_controller_poll.sv
// Bench for gc_controller_poll: measures the TX waveform, plays a controller, scores outputs per cycle.
`timescale 1ns/1ps
module tb_gc_controller_poll;

    localparam int CLK_HZ        = 10_000_000;
    localparam int POLL_HZ       = 2000;
    localparam int RX_TIMEOUT_US = 200;
    localparam int US            = CLK_HZ / 1_000_000;
    localparam int BIT_CYC       = 4 * US;
    localparam int POLL_CYC      = CLK_HZ / POLL_HZ;
    localparam int TO_CYC        = RX_TIMEOUT_US * US;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       ctrl_low = 1'b0;
    logic       data_in;
    logic       data_oe;
    logic       A, B, X, Y, start_pause, L, R, Z, D_UP, D_DOWN, D_RIGHT, D_LEFT;
    logic [7:0] JOY_X, JOY_Y, C_STICK_X, C_STICK_Y, L_TRIGGER, R_TRIGGER;
    logic       connected, update;
`ifdef GC_RUMBLE_EN
    logic       rumble = 1'b0;
    int         toggle_bit = -1;
`endif

    // Open-drain wire with pull-up: low whenever either side drives.
    assign data_in = ~(data_oe | ctrl_low);

    always #50 clk = ~clk;

    gc_controller_poll #(
        .CLK_HZ(CLK_HZ), .POLL_HZ(POLL_HZ), .RX_TIMEOUT_US(RX_TIMEOUT_US)
    ) dut (
        .clk(clk), .reset(reset), .data_in(data_in),
`ifdef GC_RUMBLE_EN
        .rumble(rumble),
`endif
        .data_oe(data_oe),
        .A(A), .B(B), .X(X), .Y(Y), .start_pause(start_pause),
        .L(L), .R(R), .Z(Z), .D_UP(D_UP), .D_DOWN(D_DOWN), .D_RIGHT(D_RIGHT), .D_LEFT(D_LEFT),
        .JOY_X(JOY_X), .JOY_Y(JOY_Y), .C_STICK_X(C_STICK_X), .C_STICK_Y(C_STICK_Y),
        .L_TRIGGER(L_TRIGGER), .R_TRIGGER(R_TRIGGER),
        .connected(connected), .update(update)
    );

    logic [11:0] buttons;
    logic [60:0] obs;
    assign buttons = {A, B, X, Y, start_pause, L, R, Z, D_UP, D_DOWN, D_RIGHT, D_LEFT};
    assign obs = {buttons, JOY_X, JOY_Y, C_STICK_X, C_STICK_Y, L_TRIGGER, R_TRIGGER, connected};

    int          checks = 0;
    int          errors = 0;
    int          cyc_n = 0;
    int          upd_cnt = 0;
    int          last_start = 0;
    bit          cmp_en = 1'b0;
    bit          oe_allowed = 1'b0;
    logic [11:0] want_btn;
    logic [47:0] want_an;
    logic        want_conn;
    logic [24:0] std_tx = {24'h400302, 1'b1};
    // Response bit index for A, B, X, Y, Start, L, R, Z, Up, Down, Right, Left.
    int          btn_pos[12] = '{56, 57, 58, 59, 60, 54, 53, 52, 51, 50, 49, 48};

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h at cycle %0d", name, got, want, cyc_n);
        end
    endtask

    task automatic finish_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    task automatic model_reset();
        want_btn  = '0;
        want_an   = {8'd128, 8'd128, 8'd128, 8'd128, 8'd0, 8'd0};
        want_conn = 1'b0;
    endtask

    // Returns the number of update pulses the transfer must produce.
    function automatic int model_apply(input logic [63:0] word, input bit complete);
        if (complete && word[63:61] == 3'b000 && word[55]) begin
            for (int i = 0; i < 12; i++) want_btn[11 - i] = word[btn_pos[i]];
            for (int k = 0; k < 6; k++) want_an[47 - 8 * k -: 8] = word[47 - 8 * k -: 8];
            want_conn = 1'b1;
            return 1;
        end
        want_conn = 1'b0;
        return 0;
    endfunction

    // Every bench wait passes through here, so the scoreboard sees every cycle.
    task automatic step();
        @(negedge clk);
        cyc_n++;
        if (update === 1'b1) upd_cnt++;
        if (cmp_en) begin
            check("outputs", obs, {want_btn, want_an, want_conn});
            if (!oe_allowed) check("oe_outside_tx", data_oe, 1'b0);
        end
    endtask

    task automatic wait_rise(input int base);
        int n = 0;
        oe_allowed = 1'b1;
        while (data_oe !== 1'b1 && n < POLL_CYC + 100) begin
            step();
            n++;
        end
        if (data_oe !== 1'b1) begin
            check("tx_start_timeout", data_oe, 1'b1);
            finish_run();
        end
        check("poll_period", cyc_n - base, POLL_CYC);
        last_start = cyc_n;
    endtask

    task automatic capture_tx(input logic [24:0] want_word);
        logic [24:0] w = '0;
        int          l, h, total = 0;
        bit          bad = 1'b0;
        for (int i = 0; i < 25; i++) begin
`ifdef GC_RUMBLE_EN
            if (i == toggle_bit) rumble = ~rumble;
`endif
            l = 0;
            while (data_oe === 1'b1 && l < BIT_CYC) begin l++; step(); end
            h = 0;
            while (data_oe === 1'b0 && h < 3 * US) begin h++; step(); end
            total += l + h;
            if (l == US && h == 3 * US)      w = {w[23:0], 1'b1};
            else if (l == 3 * US && h == US) w = {w[23:0], 1'b0};
            else begin bad = 1'b1; w = {w[23:0], 1'b0}; end
        end
        check("tx_word", w, want_word);
        check("tx_bit_shape", bad, 1'b0);
        check("tx_length", total, 25 * BIT_CYC);
        oe_allowed = 1'b0;
    endtask

    task automatic send_bits(input logic [63:0] word, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            ctrl_low = 1'b1;
            repeat (word[63 - i] ? US : 3 * US) step();
            ctrl_low = 1'b0;
            repeat (word[63 - i] ? 3 * US : US) step();
        end
    endtask

    task automatic finish_rx(input logic [63:0] word, input int nbits, input bit with_stop);
        int u0, n;
        repeat (20) step();
        u0 = upd_cnt;
        send_bits(word, nbits);
        cmp_en = 1'b0;
        if (with_stop) begin
            ctrl_low = 1'b1;
            repeat (US) step();
            ctrl_low = 1'b0;
            repeat (20) step();
        end else begin
            repeat (TO_CYC + 40) step();
        end
        n = model_apply(word, with_stop && nbits == 64);
        cmp_en = 1'b1;
        check("update_pulses", upd_cnt - u0, n);
    endtask

    task automatic transact(input logic [63:0] word, input int nbits, input bit with_stop);
        wait_rise(last_start);
        capture_tx(std_tx);
        finish_rx(word, nbits, with_stop);
    endtask

    task automatic mid_reset();
        cmp_en   = 1'b0;
        reset    = 1'b0;
        ctrl_low = 1'b0;
        step();
        check("oe_after_reset", data_oe, 1'b0);
        repeat (2) step();
        model_reset();
        check("joy_x_after_reset", JOY_X, 8'd128);
        check("connected_after_reset", connected, 1'b0);
        oe_allowed = 1'b0;
        reset      = 1'b1;
        last_start = cyc_n;
        cmp_en     = 1'b1;
    endtask

    initial begin
        #9_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc_n);
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (3) step();
        check("reset_data_oe", data_oe, 1'b0);
        check("reset_joy_x", JOY_X, 8'd128);
        check("reset_c_stick_y", C_STICK_Y, 8'd128);
        check("reset_l_trigger", L_TRIGGER, 8'd0);
        check("reset_connected", connected, 1'b0);
        check("reset_update", update, 1'b0);
        reset      = 1'b1;
        last_start = cyc_n;
        cmp_en     = 1'b1;

        // Neutral pad with A held.
        transact(64'h0180_8080_8080_0000, 64, 1'b1);
        check("p1_A", A, 1'b1);
        check("p1_joy_x", JOY_X, 8'h80);
        check("p1_d_left", D_LEFT, 1'b0);
        check("p1_connected", connected, 1'b1);

        // Everything pressed, distinct analog bytes.
        transact(64'h1FFF_1020_3040_5060, 64, 1'b1);
        check("p2_buttons", buttons, 12'hFFF);
        check("p2_joy_x", JOY_X, 8'h10);
        check("p2_c_stick_y", C_STICK_Y, 8'h40);
        check("p2_r_trigger", R_TRIGGER, 8'h60);

        // Silent controller, then a reply cut off after 40 bits.
        transact(64'h0, 0, 1'b0);
        check("p3_connected", connected, 1'b0);
        check("p3_joy_x_held", JOY_X, 8'h10);
        transact(64'h0380_0102_0304_0506, 40, 1'b0);
        check("p4_connected", connected, 1'b0);
        check("p4_buttons_held", buttons, 12'hFFF);

        // Complete reply with a reserved bit set is rejected.
        transact(64'h2080_1111_1111_1111, 64, 1'b1);
        check("p5_connected", connected, 1'b0);
        check("p5_l_trigger_held", L_TRIGGER, 8'h50);

        transact(64'h0281_7F81_2233_4455, 64, 1'b1);
        check("p6_buttons", buttons, 12'b0100_0000_0001);
        check("p6_joy_x", JOY_X, 8'h7F);
        check("p6_connected", connected, 1'b1);

        // Reset in the middle of TX bit 10.
        wait_rise(last_start);
        repeat (10 * BIT_CYC + 15) step();
        mid_reset();
        transact(64'h0180_8080_8080_0000, 64, 1'b1);
        check("p7_connected", connected, 1'b1);

        // Reset in the middle of RX bit 30.
        wait_rise(last_start);
        capture_tx(std_tx);
        repeat (20) step();
        send_bits(64'h1FFF_1020_3040_5060, 30);
        ctrl_low = 1'b1;
        repeat (5) step();
        mid_reset();
        transact(64'h1FFF_1020_3040_5060, 64, 1'b1);
        check("p8_r_trigger", R_TRIGGER, 8'h60);

`ifdef GC_RUMBLE_EN
        // Rumble sampled at TX entry; the mid-command toggle must not leak in.
        rumble     = 1'b1;
        toggle_bit = 8;
        wait_rise(last_start);
        capture_tx({24'h400303, 1'b1});
        toggle_bit = -1;
        rumble     = 1'b0;
        finish_rx(64'h0, 0, 1'b0);
        transact(64'h0180_8080_8080_0000, 64, 1'b1);
`endif

        finish_run();
    end

endmodule
